col_drain_buf: RTL and testbench
================================

COL_DRAIN_BUF -- requirements
Module: col_drain_buf

Interface
REQ-001 Parameter ROWS, default 8, number of PE rows feeding the column (>=2).
REQ-002 Parameter OUTWIDTH, default 32, result width in bits.
REQ-003 Parameter TILES, default 2, number of whole column results buffered per row (>=1).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 in_r  input  OUTWIDTH x ROWS (unpacked [0:ROWS-1])  result from PE row i.
REQ-007 in_v  input  ROWS  row i result valid; any number of rows may be valid in one cycle.
REQ-008 in_ready  output  ROWS  row i slot available; combinational from current state only.
REQ-009 flush  input  1  synchronous discard of all buffered results and pointers.
REQ-010 out_r  output  OUTWIDTH  current output word.
REQ-011 out_valid  output  1  out_r, out_row, out_last valid.
REQ-012 out_ready  input  1  downstream accepts word when out_valid&out_ready.
REQ-013 out_row  output  $clog2(ROWS)  source row of out_r.
REQ-014 out_last  output  1  out_r is row ROWS-1 of current tile.
REQ-015 tile_done  output  1  one-cycle pulse after final row of a tile is accepted.
REQ-016 ovf  output  ROWS  sticky per-row overflow flags.

Function
REQ-017 Each row i SHALL own a TILES-deep FIFO; in_ready[i] = not full; write when in_v[i]&in_ready[i].
REQ-018 in_v[i] while in_ready[i]=0 SHALL drop the word, leave FIFO unchanged, and set ovf[i].
REQ-019 Output SHALL drain rows strictly in order 0..ROWS-1 per tile, pointer rd_row in [0,ROWS-1].
REQ-020 out_valid SHALL equal not-empty of FIFO rd_row; out_r SHALL be its head word; out_row = rd_row.
REQ-021 out_r/out_row SHALL hold stable while out_valid&!out_ready.
REQ-022 On handshake, FIFO rd_row SHALL pop and rd_row SHALL increment; at ROWS-1 it SHALL wrap to 0 and tile_done SHALL pulse next cycle.
REQ-023 Minimum latency: word written at edge N SHALL be visible on out_valid after edge N (no combinational in_r to out_r path).
REQ-024 Simultaneous push and pop on the same row FIFO SHALL both take effect; occupancy unchanged; in_ready uses pre-pop occupancy (no full-bypass).
REQ-025 Rows ahead of rd_row SHALL accept writes independently (skewed systolic completion), up to TILES tiles.
REQ-026 Pointers and occupancy counters SHALL be $clog2-sized from parameters; no fixed widths; TILES non-power-of-2 SHALL wrap correctly.
REQ-027 flush SHALL empty all FIFOs, set rd_row=0, clear ovf; flush has priority over concurrent in_v and handshake; tile_done not pulsed.

Reset
REQ-028 rstn low SHALL asynchronously clear all FIFO occupancies, pointers, rd_row, ovf, and tile_done.
REQ-029 During reset: out_valid=0, out_row=0, out_last=0, tile_done=0, ovf=0, in_ready=all 1s; out_r SHALL be 0 (storage reset not required, output gated).
REQ-030 Reset deasserted mid-tile SHALL leave no residual data; first accepted word after reset is tile row 0.

Structure
REQ-031 Shared package systola_pkg SHALL hold default ROWS/OUTWIDTH/TILES constants and a result word typedef.
REQ-032 One sub-module row_fifo (parameters DEPTH, WIDTH; push/pop/full/empty/flush) SHALL be instantiated ROWS times via generate.
REQ-033 Top-level SHALL contain only read pointer, output mux, overflow and tile_done logic.

Verification
REQ-034 Rows 0..7 valid same cycle with values 0x10..0x17, out_ready=1 -> out_r 0x10..0x17 on 8 consecutive cycles, out_last on 0x17, tile_done one cycle later.
REQ-035 Skewed input: row i valid at cycle i, out_ready=1 -> out_valid gaps follow arrival; order 0..7 preserved.
REQ-036 TILES=2, out_ready=0, three writes to row 3 (0xA,0xB,0xC) -> in_ready[3]=0 after second, 0xC dropped, ovf=0x08, others 0.
REQ-037 out_ready toggling 1/0 every cycle over two tiles -> 16 words in order, each held stable while stalled, two tile_done pulses.
REQ-038 flush asserted with 5 words buffered and in_v[0]=1 same cycle -> next cycle out_valid=0, ovf=0, in_ready all 1s, rd_row=0.
REQ-039 rstn pulled low asynchronously mid-drain (rd_row=4) -> outputs reach reset values before next edge; after release first output is row 0 data.

Source files
------------

// File: rtl/col_drain_buf_pkg.sv
// Shared constants and types for the systolic column drain path.
package systola_pkg;

    localparam int DEF_ROWS     = 8;
    localparam int DEF_OUTWIDTH = 32;
    localparam int DEF_TILES    = 2;

    typedef logic [DEF_OUTWIDTH-1:0] result_t;

    // Index width that stays at least one bit for single-entry structures.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/col_drain_buf_if.sv
// Row-result ingress and serialized column egress of the drain buffer.
interface col_drain_buf_if
    import systola_pkg::*;
#(
    parameter int ROWS     = DEF_ROWS,
    parameter int OUTWIDTH = DEF_OUTWIDTH
);

    logic [OUTWIDTH-1:0]    in_r [0:ROWS-1];
    logic [ROWS-1:0]        in_v;
    logic [ROWS-1:0]        in_ready;
    logic                   flush;
    logic [OUTWIDTH-1:0]    out_r;
    logic                   out_valid;
    logic                   out_ready;
    logic [idx_w(ROWS)-1:0] out_row;
    logic                   out_last;
    logic                   tile_done;
    logic [ROWS-1:0]        ovf;

    modport master (
        output in_r, in_v, flush, out_ready,
        input  in_ready, out_r, out_valid, out_row, out_last, tile_done, ovf
    );

    modport slave (
        input  in_r, in_v, flush, out_ready,
        output in_ready, out_r, out_valid, out_row, out_last, tile_done, ovf
    );

endinterface

// File: rtl/col_drain_buf_row_fifo.sv
// Per-row result FIFO; full/empty derive from pre-update occupancy so a
// simultaneous push and pop on a full FIFO rejects the push.
module row_fifo
    import systola_pkg::*;
#(
    parameter int DEPTH = DEF_TILES,
    parameter int WIDTH = DEF_OUTWIDTH
)
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int PW = idx_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_s, pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == CW'(0));
    assign push_s  = push_i & ~full_o;
    assign pop_s   = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Next pointers and occupancy; flush overrides any push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_s) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage needs no reset; readers gate it with empty.
    always_ff @(posedge clk) begin
        if (push_s && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/col_drain_buf.sv
// Column drain buffer: per-row FIFOs absorb skewed PE results and a read
// pointer serializes them in row order, one tile at a time.
module col_drain_buf
    import systola_pkg::*;
#(
    parameter int ROWS     = DEF_ROWS,
    parameter int OUTWIDTH = DEF_OUTWIDTH,
    parameter int TILES    = DEF_TILES
)
(
    input  logic            clk,
    input  logic            rstn,
    col_drain_buf_if.slave  bus
);

    localparam int RW = idx_w(ROWS);

    logic [OUTWIDTH-1:0] head_s [0:ROWS-1];
    logic [ROWS-1:0]     full_s;
    logic [ROWS-1:0]     empty_s;
    logic [ROWS-1:0]     pop_s;
    logic [RW-1:0]       rd_row_q, rd_row_d;
    logic [ROWS-1:0]     ovf_q, ovf_d;
    logic                tile_done_q, tile_done_d;
    logic                valid_s, hs_s, last_s;

    generate
        for (genvar g = 0; g < ROWS; g++) begin : g_row
            row_fifo #(
                .DEPTH (TILES),
                .WIDTH (OUTWIDTH)
            ) u_fifo (
                .clk     (clk),
                .rstn    (rstn),
                .push_i  (bus.in_v[g]),
                .data_i  (bus.in_r[g]),
                .pop_i   (pop_s[g]),
                .flush_i (bus.flush),
                .full_o  (full_s[g]),
                .empty_o (empty_s[g]),
                .head_o  (head_s[g])
            );
            assign pop_s[g] = hs_s & (rd_row_q == RW'(g));
        end
    endgenerate

    assign valid_s = ~empty_s[rd_row_q];
    assign hs_s    = valid_s & bus.out_ready;
    assign last_s  = (rd_row_q == RW'(ROWS - 1));

    // Read pointer advance, sticky overflow capture and tile completion.
    always_comb begin
        rd_row_d    = rd_row_q;
        ovf_d       = ovf_q;
        tile_done_d = 1'b0;
        if (bus.flush) begin
            rd_row_d    = '0;
            ovf_d       = '0;
            tile_done_d = 1'b0;
        end else begin
            ovf_d = ovf_q | (bus.in_v & full_s);
            if (hs_s) begin
                if (last_s) begin
                    rd_row_d    = '0;
                    tile_done_d = 1'b1;
                end else begin
                    rd_row_d    = rd_row_q + RW'(1);
                    tile_done_d = 1'b0;
                end
            end else begin
                rd_row_d    = rd_row_q;
                tile_done_d = 1'b0;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_row_q    <= '0;
            ovf_q       <= '0;
            tile_done_q <= 1'b0;
        end else begin
            rd_row_q    <= rd_row_d;
            ovf_q       <= ovf_d;
            tile_done_q <= tile_done_d;
        end
    end

    assign bus.in_ready  = ~full_s;
    assign bus.out_valid = valid_s;
    assign bus.out_r     = valid_s ? head_s[rd_row_q] : '0;
    assign bus.out_row   = rd_row_q;
    assign bus.out_last  = valid_s & last_s;
    assign bus.tile_done = tile_done_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_col_drain_buf.sv
// Directed bench for col_drain_buf with a queue scoreboard and output monitor.
module tb_col_drain_buf;
    import systola_pkg::*;

    localparam int ROWS  = 8;
    localparam int OW    = 32;
    localparam int TILES = 2;

    typedef struct packed {
        result_t    data;
        logic [2:0] row;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    col_drain_buf_if #(.ROWS(ROWS), .OUTWIDTH(OW)) bus();

    col_drain_buf #(.ROWS(ROWS), .OUTWIDTH(OW), .TILES(TILES)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    exp_t       exp_q[$];
    int         vectors = 0;
    int         errors  = 0;
    int         td_cnt  = 0;
    int         td_base = 0;
    logic       exp_td  = 1'b0;
    logic       hold_pend = 1'b0;
    result_t    hold_data;
    logic [2:0] hold_row;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_v  = '0;
        bus.flush = 1'b0;
    endtask

    task automatic push_exp(input int r, input result_t v);
        exp_t e;
        e.data = v;
        e.row  = r[2:0];
        e.last = (r == ROWS - 1);
        exp_q.push_back(e);
    endtask

    task automatic put_row(input int r, input result_t v, input bit expect_out);
        bus.in_r[r] = v;
        bus.in_v[r] = 1'b1;
        if (expect_out) push_exp(r, v);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_left"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    // Output monitor: scoreboard pops, stall stability and tile_done timing.
    always @(negedge clk) begin
        exp_t e;
        if (bus.tile_done || exp_td) chk("tile_done", 64'(bus.tile_done), 64'(exp_td));
        if (bus.tile_done) td_cnt++;
        exp_td = 1'b0;
        if (hold_pend && bus.out_valid) begin
            chk("hold_data", 64'(bus.out_r), 64'(hold_data));
            chk("hold_row", 64'(bus.out_row), 64'(hold_row));
        end
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_out: got 0x%0h row %0d expected no output", bus.out_r, bus.out_row);
            end else begin
                e = exp_q.pop_front();
                chk("out_r", 64'(bus.out_r), 64'(e.data));
                chk("out_row", 64'(bus.out_row), 64'(e.row));
                chk("out_last", 64'(bus.out_last), 64'(e.last));
            end
            exp_td = bus.out_last && !bus.flush && rstn;
        end
        hold_pend = bus.out_valid && !bus.out_ready;
        hold_data = bus.out_r;
        hold_row  = bus.out_row;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.in_v      = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < ROWS; i++) bus.in_r[i] = '0;
        rstn = 1'b1;
        #2 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_row",   64'(bus.out_row),   64'd0);
        chk("rst_out_last",  64'(bus.out_last),  64'd0);
        chk("rst_out_r",     64'(bus.out_r),     64'd0);
        chk("rst_tile_done", 64'(bus.tile_done), 64'd0);
        chk("rst_ovf",       64'(bus.ovf),       64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'hFF);
        rstn = 1'b1;
        tick();

        // All rows in one cycle, continuous drain
        td_base = td_cnt;
        bus.out_ready = 1'b1;
        for (int i = 0; i < ROWS; i++) put_row(i, 32'h10 + 32'(i), 1'b1);
        tick();
        idle();
        chk("lat_valid", 64'(bus.out_valid), 64'd1);
        chk("lat_data",  64'(bus.out_r),     64'h10);
        repeat (8) tick();
        chk("burst_len", 64'(exp_q.size()), 64'd0);
        chk("burst_empty", 64'(bus.out_valid), 64'd0);
        wait_drain("burst", 10);
        repeat (2) tick();
        chk("burst_td_cnt", 64'(td_cnt - td_base), 64'd1);

        // Skewed arrival, one row per cycle
        td_base = td_cnt;
        for (int i = 0; i < ROWS; i++) begin
            idle();
            put_row(i, 32'h20 + 32'(i), 1'b1);
            tick();
        end
        idle();
        wait_drain("skew", 40);
        repeat (2) tick();
        chk("skew_td_cnt", 64'(td_cnt - td_base), 64'd1);

        // Overflow on row 3 with output stalled
        bus.out_ready = 1'b0;
        put_row(3, 32'hA, 1'b0);
        tick();
        chk("ovf_rdy_after1", 64'(bus.in_ready[3]), 64'd1);
        put_row(3, 32'hB, 1'b0);
        tick();
        chk("ovf_rdy_after2", 64'(bus.in_ready[3]), 64'd0);
        put_row(3, 32'hC, 1'b0);
        tick();
        idle();
        chk("ovf_flags", 64'(bus.ovf), 64'h08);
        chk("ovf_in_ready", 64'(bus.in_ready), 64'hF7);
        chk("ovf_no_out", 64'(bus.out_valid), 64'd0);
        // Complete two tiles around row 3's buffered 0xA and 0xB
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < ROWS; i++) begin
                if (i == 3) push_exp(3, (t == 0) ? 32'hA : 32'hB);
                else put_row(i, 32'h90 + 32'(t * 16 + i), 1'b1);
            end
            tick();
            idle();
        end
        bus.out_ready = 1'b1;
        wait_drain("ovf_drain", 40);
        repeat (2) tick();

        // Two tiles drained with out_ready toggling every cycle
        bus.out_ready = 1'b0;
        td_base = td_cnt;
        for (int i = 0; i < ROWS; i++) put_row(i, 32'h30 + 32'(i), 1'b1);
        tick();
        for (int i = 0; i < ROWS; i++) put_row(i, 32'h40 + 32'(i), 1'b1);
        tick();
        idle();
        for (int c = 0; c < 80 && exp_q.size() != 0; c++) begin
            bus.out_ready = c[0];
            tick();
        end
        bus.out_ready = 1'b0;
        wait_drain("toggle", 4);
        repeat (2) tick();
        chk("toggle_td_cnt", 64'(td_cnt - td_base), 64'd2);

        // Flush mid-tile with 5 words buffered and a concurrent write
        for (int i = 0; i < 7; i++) put_row(i, 32'h50 + 32'(i), 1'b0);
        tick();
        idle();
        push_exp(0, 32'h50);
        push_exp(1, 32'h51);
        bus.out_ready = 1'b1;
        repeat (2) tick();
        bus.out_ready = 1'b0;
        chk("pre_flush_row", 64'(bus.out_row), 64'd2);
        chk("pre_flush_ovf", 64'(bus.ovf), 64'h08);
        bus.flush = 1'b1;
        put_row(0, 32'h99, 1'b0);
        tick();
        idle();
        chk("flush_valid",    64'(bus.out_valid), 64'd0);
        chk("flush_ovf",      64'(bus.ovf),       64'd0);
        chk("flush_in_ready", 64'(bus.in_ready),  64'hFF);
        chk("flush_row",      64'(bus.out_row),   64'd0);
        chk("flush_td",       64'(bus.tile_done), 64'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < ROWS; i++) put_row(i, 32'h60 + 32'(i), 1'b1);
        tick();
        idle();
        wait_drain("post_flush", 20);
        repeat (2) tick();

        // Asynchronous reset while rd_row is 4
        for (int i = 0; i < ROWS; i++) put_row(i, 32'h70 + 32'(i), 1'b1);
        tick();
        idle();
        for (int n = 0; n < 20 && bus.out_row != 3'd4; n++) tick();
        chk("mid_row", 64'(bus.out_row), 64'd4);
        #2 rstn = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_valid",    64'(bus.out_valid), 64'd0);
        chk("arst_row",      64'(bus.out_row),   64'd0);
        chk("arst_last",     64'(bus.out_last),  64'd0);
        chk("arst_out_r",    64'(bus.out_r),     64'd0);
        chk("arst_in_ready", 64'(bus.in_ready),  64'hFF);
        chk("arst_td",       64'(bus.tile_done), 64'd0);
        repeat (2) tick();
        rstn = 1'b1;
        tick();
        chk("post_rst_empty", 64'(bus.out_valid), 64'd0);
        for (int i = 0; i < ROWS; i++) put_row(i, 32'h80 + 32'(i), 1'b1);
        tick();
        idle();
        wait_drain("post_rst", 20);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
